// File: rtl/keyboard_buffer_if.sv
// Memory-subsystem side of the PS/2 key buffer: head code, status flags and the pop strobe.
// The memory subsystem is the master; the keyboard buffer is the slave.
interface keyboard_buffer_if;
  logic       clean_key_buffer;
  logic [7:0] pressed_key;
  logic       key_valid;
  logic       overflow;
  logic       frame_error;

  modport master (
    output clean_key_buffer,
    input  pressed_key,
    input  key_valid,
    input  overflow,
    input  frame_error
  );

  modport slave (
    input  clean_key_buffer,
    output pressed_key,
    output key_valid,
    output overflow,
    output frame_error
  );
endinterface

// File: rtl/keyboard_buffer.sv
// PS/2 device-to-host receiver with break/control filtering and a small make-code FIFO.
// The FIFO head is presented to the CPU until the memory subsystem pops it.
module keyboard_buffer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic             CLK_cpu,
  input  logic             RST_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  keyboard_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   PTR_WRAP = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Pin synchronisers; idle line level is high.
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic fall;

  always_ff @(posedge CLK_cpu or negedge RST_n) begin
    if (!RST_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;

  // Frame FSM with the abandon timer and registered byte/error strobes.
  state_e        state_q;
  logic [7:0]    shreg_q;
  logic [2:0]    bit_cnt_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic          byte_done_q;
  logic [7:0]    byte_q;
  logic          frame_error_q;

  always_ff @(posedge CLK_cpu or negedge RST_n) begin
    if (!RST_n) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      byte_done_q   <= 1'b0;
      byte_q        <= '0;
      frame_error_q <= 1'b0;
    end else begin
      byte_done_q   <= 1'b0;
      frame_error_q <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        unique case (state_q)
          StIdle: begin
            // A high sample here is a spurious edge, silently ignored.
            if (!dat_s2_q) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shreg_q   <= {dat_s2_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= dat_s2_q;
            state_q  <= StStop;
          end
          StStop: begin
            if (dat_s2_q && (^{shreg_q, parity_q})) begin
              byte_done_q <= 1'b1;
              byte_q      <= shreg_q;
            end else begin
              frame_error_q <= 1'b1;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q == StIdle) begin
        tmo_q <= '0;
      end else if (tmo_q == TMO_LAST) begin
        state_q       <= StIdle;
        tmo_q         <= '0;
        frame_error_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + TMO_ONE;
      end
    end
  end

  // Scan-code decoder. The E0 prefix is swallowed; it does not alter which codes are queued,
  // so no extended-key state needs to be kept.
  logic is_ctrl;
  logic push;
  logic brk_q;

  always_comb begin
    is_ctrl = 1'b0;
    case (byte_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                  is_ctrl = 1'b0;
    endcase
  end

  assign push = byte_done_q & ~is_ctrl & (byte_q != 8'hF0) & (byte_q != 8'hE0) & ~brk_q;

  always_ff @(posedge CLK_cpu or negedge RST_n) begin
    if (!RST_n) begin
      brk_q <= 1'b0;
    end else if (byte_done_q) begin
      if (byte_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else if ((byte_q != 8'hE0) && !is_ctrl) begin
        brk_q <= 1'b0;
      end
    end
  end

  // Make-code FIFO; pointers carry one extra wrap bit.
  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        empty, full, do_pop, do_push;
  logic        overflow_q;

  assign empty   = (wptr_q == rptr_q);
  assign full    = ((wptr_q ^ rptr_q) == PTR_WRAP);
  assign do_pop  = bus.clean_key_buffer & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLK_cpu or negedge RST_n) begin
    if (!RST_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop) rptr_q <= rptr_q + PTR_ONE;
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_cpu) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= byte_q;
  end

  assign bus.pressed_key = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign bus.key_valid   = ~empty;
  assign bus.overflow    = overflow_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_keyboard_buffer.sv
// Self-checking bench for keyboard_buffer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_keyboard_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 200;
  localparam int          HALF  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  keyboard_buffer_if bus ();

  keyboard_buffer #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK_cpu  (clk),
    .RST_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int err_cnt = 0;
  event stop_edge;

  always @(negedge clk) if (bus.frame_error === 1'b1) err_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == n - 1) -> stop_edge;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    send_bits(bits, 11);
  endtask

  task automatic pop();
    @(negedge clk);
    bus.clean_key_buffer = 1'b1;
    @(negedge clk);
    bus.clean_key_buffer = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Sends a good frame and raises the pop strobe in the cycle the decoded byte is pushed.
  task automatic send_with_pop(input logic [7:0] code);
    bit found;
    found = 1'b0;
    fork
      send_frame(code, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (dut.byte_done_q === 1'b1) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          bus.clean_key_buffer = 1'b1;
          @(negedge clk);
          bus.clean_key_buffer = 1'b0;
        end
      end
    join
    check("byte_done_seen", 32'(found), 32'd1);
  endtask

  typedef struct {
    int         pops;
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_valid;
    logic [7:0] exp_key;
    int         exp_err;
    bit         exp_ovf;
  } vec_t;

  vec_t vecs[15];

  // Reference model state
  logic [7:0] mq[$];
  bit m_brk, m_ovf;
  int m_err, err_base;

  function automatic bit is_ctrl(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit bad);
    if (bad) m_err++;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0 || is_ctrl(b)) begin end
    else if (m_brk) m_brk = 1'b0;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1'b1;
  endfunction

  initial begin
    logic [7:0] makes[10];
    logic [7:0] ctrls[6];
    logic [7:0] exp_seq[4];
    int e0, lat;

    makes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h1C, 8'h75, 8'h5A, 8'h29, 8'h33};
    ctrls = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    vecs[0]  = '{1, 8'hF0, 0, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 8'h1C, 0, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{0, 8'hE0, 0, 0, 0, 8'h00, 0, 0};
    vecs[3]  = '{0, 8'h75, 0, 0, 1, 8'h75, 0, 0};
    vecs[4]  = '{1, 8'hE0, 0, 0, 0, 8'h00, 0, 0};
    vecs[5]  = '{0, 8'hF0, 0, 0, 0, 8'h00, 0, 0};
    vecs[6]  = '{0, 8'h75, 0, 0, 0, 8'h00, 0, 0};
    vecs[7]  = '{0, 8'h1C, 1, 0, 0, 8'h00, 1, 0};
    vecs[8]  = '{0, 8'h1C, 0, 1, 0, 8'h00, 1, 0};
    vecs[9]  = '{0, 8'hFA, 0, 0, 0, 8'h00, 0, 0};
    vecs[10] = '{0, 8'h16, 0, 0, 1, 8'h16, 0, 0};
    vecs[11] = '{0, 8'h1E, 0, 0, 1, 8'h16, 0, 0};
    vecs[12] = '{0, 8'h26, 0, 0, 1, 8'h16, 0, 0};
    vecs[13] = '{0, 8'h25, 0, 0, 1, 8'h16, 0, 0};
    vecs[14] = '{0, 8'h2E, 0, 0, 1, 8'h16, 0, 1};

    bus.clean_key_buffer = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_key_valid", 32'(bus.key_valid), 32'd0);
    check("rst_pressed_key", 32'(bus.pressed_key), 32'h00);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_frame_error", 32'(bus.frame_error), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Make-code latency from the stop-bit pin edge
    lat = 99;
    fork
      send_frame(8'h1C, 1'b0, 1'b0);
      begin
        @(stop_edge);
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (bus.key_valid === 1'b1 && lat == 99) lat = i;
        end
      end
    join
    check("latency_le5", 32'(lat <= 5), 32'd1);
    check("make_key", 32'(bus.pressed_key), 32'h1C);

    foreach (vecs[i]) begin
      for (int p = 0; p < vecs[i].pops; p++) pop();
      e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      check($sformatf("vec%0d_valid", i), 32'(bus.key_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_key", i), 32'(bus.pressed_key), 32'(vecs[i].exp_key));
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
    end

    exp_seq = '{8'h16, 8'h1E, 8'h26, 8'h25};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d", i), 32'(bus.pressed_key), 32'(exp_seq[i]));
      pop();
    end
    check("ovf_empty_valid", 32'(bus.key_valid), 32'd0);
    check("ovf_empty_key", 32'(bus.pressed_key), 32'h00);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Reset during a partial frame with a non-empty FIFO
    send_frame(8'h16, 1'b0, 1'b0);
    send_bits(11'b000_0000_0110, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.key_valid), 32'd0);
    check("midrst_key", 32'(bus.pressed_key), 32'h00);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    check("midrst_err", 32'(bus.frame_error), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    check("midrst_next_key", 32'(bus.pressed_key), 32'h5A);
    pop();

    // Timeout on a frame abandoned after start + 4 data bits
    e0 = err_cnt;
    send_bits(11'b000_0001_0110, 5);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_err", 32'(err_cnt - e0), 32'd1);
    check("tmo_valid", 32'(bus.key_valid), 32'd0);
    send_frame(8'h29, 1'b0, 1'b0);
    check("tmo_next_key", 32'(bus.pressed_key), 32'h29);
    check("tmo_no_extra_err", 32'(err_cnt - e0), 32'd1);
    pop();

    // Pop coinciding with a push on a full FIFO
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(makes[i], 1'b0, 1'b0);
    send_with_pop(8'h2E);
    check("full_pp_ovf", 32'(bus.overflow), 32'd0);
    exp_seq = '{8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_pp_pop%0d", i), 32'(bus.pressed_key), 32'(exp_seq[i]));
      pop();
    end
    check("full_pp_empty", 32'(bus.key_valid), 32'd0);

    // Pop coinciding with a push on an empty FIFO
    send_with_pop(8'h33);
    check("empty_pp_valid", 32'(bus.key_valid), 32'd1);
    check("empty_pp_key", 32'(bus.pressed_key), 32'h33);
    pop();
    check("empty_pp_after", 32'(bus.key_valid), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    mq.delete();
    m_brk = 1'b0;
    m_ovf = 1'b0;
    m_err = 0;
    err_base = err_cnt;
    for (int s = 0; s < 50; s++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        pop();
        if (mq.size() > 0) void'(mq.pop_front());
      end else begin
        r = $urandom_range(0, 7);
        if (r < 4) begin
          b = makes[$urandom_range(0, 9)];
          send_frame(b, 1'b0, 1'b0);
          model_frame(b, 1'b0);
        end else if (r == 4) begin
          send_frame(8'hF0, 1'b0, 1'b0);
          model_frame(8'hF0, 1'b0);
        end else if (r == 5) begin
          send_frame(8'hE0, 1'b0, 1'b0);
          model_frame(8'hE0, 1'b0);
        end else if (r == 6) begin
          b = ctrls[$urandom_range(0, 5)];
          send_frame(b, 1'b0, 1'b0);
          model_frame(b, 1'b0);
        end else begin
          b = 8'($urandom);
          send_frame(b, 1'b1, 1'b0);
          model_frame(b, 1'b1);
        end
      end
      check($sformatf("rnd%0d_valid", s), 32'(bus.key_valid), 32'(mq.size() > 0));
      check($sformatf("rnd%0d_key", s), 32'(bus.pressed_key),
            (mq.size() > 0) ? 32'(mq[0]) : 32'h00);
      check($sformatf("rnd%0d_ovf", s), 32'(bus.overflow), 32'(m_ovf));
      check($sformatf("rnd%0d_err", s), 32'(err_cnt - err_base), 32'(m_err));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
